cpu_clk_ctrl: RTL and testbench

//  Clock-enable sequencer for the CPU core. Replaces the raw divided CPU clock.

---
 rtl/cpu_clk_ctrl.sv | 153 +++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: free-run / halt / single-step / stop-on-breakpoint,
// emitting a one-clk cpu_ce pulse at a prescaled rate.
module cpu_clk_ctrl #(
    parameter int unsigned FAST_DIV   = 8,
    parameter int unsigned SLOW_DIV   = 2**27,
    parameter int unsigned DEB_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_run,
    input  logic        sw_slow,
    input  logic        btn_step,
    input  logic        brk,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic        brk_hold,
    output logic [31:0] cycle_cnt
);

    localparam logic [31:0] FAST_M1 = 32'(FAST_DIV - 1);
    localparam logic [31:0] SLOW_M1 = 32'(SLOW_DIV - 1);
    localparam int          DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_M1 = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    // ---------------- input synchronisers ----------------
    logic [2:0] sync_q1, sync_q2;
    logic       sw_run_s, sw_slow_s, btn_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {btn_step, sw_slow, sw_run};
            sync_q2 <= sync_q1;
        end
    end

    assign sw_run_s  = sync_q2[0];
    assign sw_slow_s = sync_q2[1];
    assign btn_s     = sync_q2[2];

    // ---------------- prescaler ----------------
    logic [31:0] div_cnt;
    logic [31:0] div_m1;
    logic        slow_d, slow_chg, tick;

    assign div_m1   = sw_slow_s ? SLOW_M1 : FAST_M1;
    assign slow_chg = sw_slow_s ^ slow_d;
    // A rate change restarts the period; suppressing tick avoids a short pulse.
    assign tick     = ~slow_chg & (div_cnt == div_m1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            slow_d  <= 1'b0;
        end else begin
            slow_d <= sw_slow_s;
            if (slow_chg || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 32'd1;
        end
    end

    // ---------------- step button debouncer ----------------
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_lvl, deb_prev, step_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt  <= '0;
            deb_lvl  <= 1'b0;
            deb_prev <= 1'b0;
        end else begin
            deb_prev <= deb_lvl;
            if (btn_s == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_M1) begin
                deb_lvl <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign step_req = deb_lvl & ~deb_prev;

    // ---------------- sequencer FSM ----------------
    state_t cur_state, nxt_state;
    logic   ce_d, hold_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= HALT;
            cpu_ce    <= 1'b0;
            brk_hold  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cpu_ce    <= ce_d;
            brk_hold  <= hold_d;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            HALT: begin
                if (sw_run_s && !brk_hold)
                    nxt_state = RUN;
                else if (step_req)
                    nxt_state = STEP;
            end
            RUN: begin
                if (brk || !sw_run_s)
                    nxt_state = HALT;
            end
            STEP: begin
                // a step always completes; run switch is honoured from HALT
                if (tick)
                    nxt_state = HALT;
            end
            default: nxt_state = HALT;
        endcase
    end

    always_comb begin
        ce_d   = tick & (((cur_state == RUN) & ~brk) | (cur_state == STEP));
        hold_d = brk_hold;
        if ((cur_state == RUN) && brk)
            hold_d = 1'b1;
        else if (!sw_run_s)
            hold_d = 1'b0;
    end

    assign state = cur_state;

    // ---------------- pulse counter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cycle_cnt <= '0;
        else if (cpu_ce)
            cycle_cnt <= cycle_cnt + 32'd1;
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with FAST_DIV=4, SLOW_DIV=16, DEB_CYCLES=3.
// Edge numbers in comments count posedges after the first reset release (E1..).
module tb_cpu_clk_ctrl;

    logic        clk;
    logic        rst;
    logic        sw_run, sw_slow, btn_step, brk;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        brk_hold;
    logic [31:0] cycle_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    int          ce_seen = 0;
    logic [31:0] hist;

    cpu_clk_ctrl #(
        .FAST_DIV  (4),
        .SLOW_DIV  (16),
        .DEB_CYCLES(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_run   (sw_run),
        .sw_slow  (sw_slow),
        .btn_step (btn_step),
        .brk      (brk),
        .cpu_ce   (cpu_ce),
        .state    (state),
        .brk_hold (brk_hold),
        .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance n falling edges, counting cpu_ce pulses seen at each
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (cpu_ce) ce_seen++;
        end
    endtask

    task automatic window(input int n);
        hist = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hist[i] = cpu_ce;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sw_run = 1'b0; sw_slow = 1'b0; btn_step = 1'b0; brk = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_hold", 32'(brk_hold), 32'd0);
        check("rst_cnt", cycle_cnt, 32'd0);

        // ---- 1: fast free-run ----
        rst = 1'b1; sw_run = 1'b1;
        cyc(2);                                   // E2
        check("t1_halt_e2", 32'(state), 32'd0);
        cyc(1);                                   // E3
        check("t1_run_e3", 32'(state), 32'd1);
        check("t1_ce_e3", 32'(cpu_ce), 32'd0);
        cyc(1);                                   // E4: first pulse
        check("t1_ce_e4", 32'(cpu_ce), 32'd1);
        window(16);                               // E5..E20: pulses E8,E12,E16,E20
        check("t1_period4", hist, 32'h0000_8888);
        cyc(1);                                   // E21
        check("t1_cnt5", cycle_cnt, 32'd5);
        check("t1_ce_e21", 32'(cpu_ce), 32'd0);

        // ---- 2: switch to slow; prescaler clear at E24, next pulse E40 ----
        sw_slow = 1'b1;
        window(19);                               // E22..E40
        check("t2_first_slow", hist, 32'h0004_0000);
        window(16);                               // E41..E56
        check("t2_period16", hist, 32'h0000_8000);
        check("t2_cnt6", cycle_cnt, 32'd6);
        cyc(1);                                   // E57
        check("t2_cnt7", cycle_cnt, 32'd7);

        // ---- 3: halt, bouncy button, one step ----
        sw_run = 1'b0;
        cyc(3);                                   // E60
        check("t3_halt", 32'(state), 32'd0);
        ce_seen = 0;
        btn_step = 1'b1; cyc(1);                  // E61
        btn_step = 1'b0; cyc(1);                  // E62
        btn_step = 1'b1; cyc(5);                  // E67: debounced level rises
        check("t3_still_halt", 32'(state), 32'd0);
        cyc(1);                                   // E68
        check("t3_step", 32'(state), 32'd2);
        cyc(3);                                   // E71
        check("t3_step_wait", 32'(state), 32'd2);
        check("t3_ce_wait", 32'(cpu_ce), 32'd0);
        cyc(1);                                   // E72: tick ends step
        check("t3_step_ce", 32'(cpu_ce), 32'd1);
        check("t3_back_halt", 32'(state), 32'd0);
        btn_step = 1'b0;
        cyc(8);                                   // E80
        check("t3_one_pulse", 32'(ce_seen), 32'd1);
        check("t3_halt_end", 32'(state), 32'd0);
        check("t3_cnt8", cycle_cnt, 32'd8);

        // ---- 4: breakpoint coincident with tick ----
        sw_run = 1'b1;
        cyc(3);                                   // E83
        check("t4_run", 32'(state), 32'd1);
        ce_seen = 0;
        cyc(4);                                   // E87: tick pending this cycle
        check("t4_run_e87", 32'(state), 32'd1);
        brk = 1'b1;
        cyc(1);                                   // E88
        check("t4_brk_noce", 32'(cpu_ce), 32'd0);
        check("t4_brk_halt", 32'(state), 32'd0);
        check("t4_brk_hold", 32'(brk_hold), 32'd1);
        brk = 1'b0;
        cyc(18);                                  // E106
        check("t4_stay_halt", 32'(state), 32'd0);
        check("t4_no_pulses", 32'(ce_seen), 32'd0);
        check("t4_hold_kept", 32'(brk_hold), 32'd1);

        // ---- 5: re-arm, counter wrap ----
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt;
        check("t5_preload", cycle_cnt, 32'hFFFF_FFFF);
        sw_run = 1'b0;
        cyc(2);                                   // E108
        check("t5_hold_e108", 32'(brk_hold), 32'd1);
        cyc(1);                                   // E109
        check("t5_hold_clr", 32'(brk_hold), 32'd0);
        sw_run = 1'b1;
        cyc(3);                                   // E112
        check("t5_rerun", 32'(state), 32'd1);
        cyc(8);                                   // E120
        check("t5_ce", 32'(cpu_ce), 32'd1);
        check("t5_cnt_max", cycle_cnt, 32'hFFFF_FFFF);
        cyc(1);                                   // E121
        check("t5_wrap", cycle_cnt, 32'd0);

        // ---- 6: reset during a step before its tick ----
        sw_run = 1'b0;
        cyc(3);                                   // E124
        check("t6_halt", 32'(state), 32'd0);
        btn_step = 1'b1;
        cyc(6);                                   // E130
        check("t6_step", 32'(state), 32'd2);
        cyc(1);                                   // E131
        check("t6_ce_pre", 32'(cpu_ce), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_ce", 32'(cpu_ce), 32'd0);
        check("t6_rst_hold", 32'(brk_hold), 32'd0);
        check("t6_rst_cnt", cycle_cnt, 32'd0);
        btn_step = 1'b0;
        ce_seen = 0;
        cyc(1);
        rst = 1'b1;
        cyc(20);
        check("t6_no_ce", 32'(ce_seen), 32'd0);
        check("t6_halt_after", 32'(state), 32'd0);
        check("t6_cnt_after", cycle_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
